// File: rtl/pc_sequencer_pkg.sv
// Shared CPU fetch definitions: sequencer state encoding, PC width, reset PC.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pc_sequencer_pkg;

  localparam int unsigned PC_W = 16;

  // Default PC loaded on reset; the top-level RESET_PC parameter defaults to this.
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_e;

  // Sequential fetch step; instructions are 2 bytes, wraps modulo 2^16.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/pc_sequencer_pc_hold_reg.sv
// PC holding register: 16-bit, write-enabled, async active-low reset to RESET_VAL.
// Latency: one cycle from we_i/d_i to q_o.
// Backpressure: none; holds its value whenever we_i is low.
// Ports: clk, rst_n, we_i (load enable), d_i (next value), q_o (current PC).
module pc_hold_reg
  import pc_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VAL = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [PC_W-1:0] d_i,
  output logic [PC_W-1:0] q_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (we_i) begin
      pc_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/FETCH/WAIT/HALT FSM driving instruction memory requests.
// Latency: one cycle from completion (imem_ready_i while requesting) to the next PC.
// Backpressure: imem_ready_i low holds pc_o and the request; stall_i forces a re-fetch.
// Ports: clk, rst_n; stall_i, redirect_i/redirect_pc_i, halt_i, imem_ready_i in;
//        imem_req_o, pc_o, pc_plus2_o, fetch_valid_o, halted_o out.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            halt_i,
  input  logic            imem_ready_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_plus2_o,
  output logic            fetch_valid_o,
  output logic            halted_o
);

  seq_state_e      state_q, state_d;
  logic            pend_vld_q, pend_vld_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;

  logic            pc_we;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] pc_cur;

  pc_hold_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_hold_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (pc_we),
    .d_i   (pc_nxt),
    .q_o   (pc_cur)
  );

  always_comb begin
    state_d       = state_q;
    pend_vld_d    = pend_vld_q;
    pend_pc_d     = pend_pc_q;
    pc_we         = 1'b0;
    pc_nxt        = pc_cur;
    imem_req_o    = 1'b0;
    fetch_valid_o = 1'b0;
    halted_o      = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        if (redirect_i) begin
          pc_we  = 1'b1;
          pc_nxt = redirect_pc_i;
        end
        state_d = ST_FETCH;
      end

      ST_FETCH, ST_WAIT: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          // Completion. A redirect arriving in this very cycle is newer than
          // any pending target, so it wins.
          pend_vld_d = 1'b0;
          state_d    = ST_FETCH;
          if (redirect_i) begin
            pc_we  = 1'b1;
            pc_nxt = redirect_pc_i;
          end else if (pend_vld_q) begin
            pc_we  = 1'b1;
            pc_nxt = pend_pc_q;
          end else if (stall_i) begin
            // IF/ID cannot take it: drop the word and re-fetch the same PC.
          end else if (halt_i) begin
            fetch_valid_o = 1'b1;
            state_d       = ST_HALT;
          end else begin
            fetch_valid_o = 1'b1;
            pc_we         = 1'b1;
            pc_nxt        = pc_inc(pc_cur);
          end
        end else begin
          // The outstanding access must finish at the old address; remember
          // where to go and squash its response on arrival.
          if (redirect_i) begin
            pend_vld_d = 1'b1;
            pend_pc_d  = redirect_pc_i;
          end
          state_d = ST_WAIT;
        end
      end

      ST_HALT: begin
        halted_o = 1'b1;
        if (redirect_i) begin
          pc_we   = 1'b1;
          pc_nxt  = redirect_pc_i;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  assign pc_o       = pc_cur;
  assign pc_plus2_o = pc_inc(pc_cur);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic        halt_i;
  logic        imem_ready_i;
  logic        imem_req_o;
  logic [15:0] pc_o;
  logic [15:0] pc_plus2_o;
  logic        fetch_valid_o;
  logic        halted_o;

  int errors = 0;
  int checks = 0;

  // Expected PC of every valid fetch, pushed when the stimulus is driven.
  logic [15:0] exp_q[$];

  pc_sequencer #(
    .RESET_PC (16'h0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .imem_ready_i  (imem_ready_i),
    .imem_req_o    (imem_req_o),
    .pc_o          (pc_o),
    .pc_plus2_o    (pc_plus2_o),
    .fetch_valid_o (fetch_valid_o),
    .halted_o      (halted_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard consumer: sampled 1 time unit before each rising edge.
  always begin
    logic [15:0] exp;
    @(negedge clk);
    #4;
    if (fetch_valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: fetch_valid_o=1 at pc_o=%h, no fetch expected", pc_o);
      end else begin
        exp = exp_q.pop_front();
        if (pc_o !== exp) begin
          errors++;
          $display("FAIL fetch_pc: got %h want %h", pc_o, exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 16'h0000;
    halt_i = 1'b0; imem_ready_i = 1'b0;
    #1;
    checks++; if (pc_o !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", pc_o); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req_o); end
    checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", fetch_valid_o); end
    checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted_o); end
    checks++; if (pc_plus2_o !== 16'h0002) begin errors++; $display("FAIL reset_pc_plus2: got %h want 0002", pc_plus2_o); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL boot_req: got %b want 0", imem_req_o); end
    @(negedge clk);
    #1;
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imem_req_o); end
    checks++; if (pc_o !== 16'h0000) begin errors++; $display("FAIL first_req_pc: got %h want 0000", pc_o); end
  endtask

  task automatic test_sequential();
    logic [15:0] exp_pc;
    exp_pc = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      imem_ready_i = 1'b1;
      exp_q.push_back(exp_pc);
      #1;
      checks++; if (pc_o !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc_o, exp_pc); end
      checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b want 1", i, fetch_valid_o); end
      exp_pc = exp_pc + 16'd2;
    end
    @(negedge clk);
    imem_ready_i = 1'b0;
    #1;
    checks++; if (pc_o !== 16'h000A) begin errors++; $display("FAIL seq_end_pc: got %h want 000a", pc_o); end
    checks++; if (pc_plus2_o !== 16'h000C) begin errors++; $display("FAIL seq_pc_plus2: got %h want 000c", pc_plus2_o); end
  endtask

  // Redirect at a completion; leaves the bench at a negedge with ready low.
  task automatic do_redirect(input logic [15:0] target);
    @(negedge clk);
    redirect_i = 1'b1; redirect_pc_i = target; imem_ready_i = 1'b1;
    #1;
    checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b want 0", fetch_valid_o); end
    @(negedge clk);
    redirect_i = 1'b0; imem_ready_i = 1'b0;
    #1;
    checks++; if (pc_o !== target) begin errors++; $display("FAIL redir_pc: got %h want %h", pc_o, target); end
  endtask

  task automatic test_wrap();
    do_redirect(16'hFFFE);
    checks++; if (pc_plus2_o !== 16'h0000) begin errors++; $display("FAIL wrap_plus2: got %h want 0000", pc_plus2_o); end
    @(negedge clk);
    imem_ready_i = 1'b1;
    exp_q.push_back(16'hFFFE);
    @(negedge clk);
    imem_ready_i = 1'b0;
    #1;
    checks++; if (pc_o !== 16'h0000) begin errors++; $display("FAIL wrap_pc: got %h want 0000", pc_o); end
  endtask

  task automatic test_redirect_wait();
    do_redirect(16'h0010);
    // wait cycle 1 already in progress (ready low); redirect in wait cycle 2
    @(negedge clk);
    redirect_i = 1'b1; redirect_pc_i = 16'h0200;
    #1;
    checks++; if (pc_o !== 16'h0010) begin errors++; $display("FAIL rw_pc_hold: got %h want 0010", pc_o); end
    @(negedge clk);
    redirect_i = 1'b0; redirect_pc_i = 16'h0000;
    #1;
    checks++; if (pc_o !== 16'h0010 || imem_req_o !== 1'b1) begin
      errors++; $display("FAIL rw_wait3: got pc=%h req=%b want pc=0010 req=1", pc_o, imem_req_o);
    end
    @(negedge clk);
    imem_ready_i = 1'b1;
    #1;
    checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL rw_discard: got %b want 0", fetch_valid_o); end
    @(negedge clk);
    exp_q.push_back(16'h0200);
    #1;
    checks++; if (pc_o !== 16'h0200 || imem_req_o !== 1'b1) begin
      errors++; $display("FAIL rw_target: got pc=%h req=%b want pc=0200 req=1", pc_o, imem_req_o);
    end
    @(negedge clk);
    imem_ready_i = 1'b0;
    #1;
    checks++; if (pc_o !== 16'h0202) begin errors++; $display("FAIL rw_after: got %h want 0202", pc_o); end
  endtask

  task automatic test_stall_halt();
    do_redirect(16'h0020);
    @(negedge clk);
    imem_ready_i = 1'b1; stall_i = 1'b1; halt_i = 1'b1;
    #1;
    checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL stall_valid: got %b want 0", fetch_valid_o); end
    @(negedge clk);
    imem_ready_i = 1'b0; stall_i = 1'b0; halt_i = 1'b0;
    #1;
    checks++; if (pc_o !== 16'h0020 || imem_req_o !== 1'b1 || halted_o !== 1'b0) begin
      errors++; $display("FAIL stall_refetch: got pc=%h req=%b halted=%b want pc=0020 req=1 halted=0",
                         pc_o, imem_req_o, halted_o);
    end
  endtask

  task automatic test_halt();
    do_redirect(16'h0030);
    @(negedge clk);
    imem_ready_i = 1'b1; halt_i = 1'b1;
    exp_q.push_back(16'h0030);
    @(negedge clk);
    imem_ready_i = 1'b0; halt_i = 1'b0;
    #1;
    checks++; if (halted_o !== 1'b1 || imem_req_o !== 1'b0 || pc_o !== 16'h0030) begin
      errors++; $display("FAIL halt_enter: got halted=%b req=%b pc=%h want halted=1 req=0 pc=0030",
                         halted_o, imem_req_o, pc_o);
    end
    @(negedge clk);
    imem_ready_i = 1'b1; stall_i = 1'b1; halt_i = 1'b1;
    #1;
    checks++; if (halted_o !== 1'b1 || fetch_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      errors++; $display("FAIL halt_ignore: got halted=%b valid=%b req=%b want 1 0 0",
                         halted_o, fetch_valid_o, imem_req_o);
    end
    @(negedge clk);
    imem_ready_i = 1'b0; stall_i = 1'b0; halt_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 16'h0040;
    #1;
    checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL halt_redir_cycle: got %b want 1", halted_o); end
    @(negedge clk);
    redirect_i = 1'b0; redirect_pc_i = 16'h0000;
    #1;
    checks++; if (halted_o !== 1'b0 || pc_o !== 16'h0040 || imem_req_o !== 1'b1) begin
      errors++; $display("FAIL halt_resume: got halted=%b pc=%h req=%b want 0 0040 1",
                         halted_o, pc_o, imem_req_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_redirect(16'h0050);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc_o !== 16'h0000 || imem_req_o !== 1'b0 || fetch_valid_o !== 1'b0 || halted_o !== 1'b0) begin
      errors++; $display("FAIL async_reset: got pc=%h req=%b valid=%b halted=%b want 0000 0 0 0",
                         pc_o, imem_req_o, fetch_valid_o, halted_o);
    end
    imem_ready_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req_o !== 1'b0 || fetch_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_boot: got req=%b valid=%b want 0 0", imem_req_o, fetch_valid_o);
    end
    @(negedge clk);
    exp_q.push_back(16'h0000);
    #1;
    checks++; if (pc_o !== 16'h0000 || fetch_valid_o !== 1'b1) begin
      errors++; $display("FAIL rst_restart: got pc=%h valid=%b want 0000 1", pc_o, fetch_valid_o);
    end
    @(negedge clk);
    imem_ready_i = 1'b0;
    #1;
    checks++; if (pc_o !== 16'h0002) begin errors++; $display("FAIL rst_next: got %h want 0002", pc_o); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_redirect_wait();
    test_stall_halt();
    test_halt();
    test_reset_mid_wait();
    @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port stall_i  input  1  hazard stall: IF/ID cannot accept an instruction this cycle.
REQ-005 SHALL have port redirect_i  input  1  taken-branch/jump redirect request.
REQ-006 SHALL have port redirect_pc_i  input  16  redirect target, valid when redirect_i=1.
REQ-007 SHALL have port halt_i  input  1  the instruction returned this cycle decodes as HLT.
REQ-008 SHALL have port imem_ready_i  input  1  instruction memory returns data for the current request this cycle.
REQ-009 SHALL have port imem_req_o  output  1  fetch request to instruction memory, address pc_o.
REQ-010 SHALL have port pc_o  output  16  current fetch PC.
REQ-011 SHALL have port pc_plus2_o  output  16  pc_o+2, combinational, modulo 2^16.
REQ-012 SHALL have port fetch_valid_o  output  1  returned instruction is valid for IF/ID this cycle.
REQ-013 SHALL have port halted_o  output  1  sequencer is in HALT.

Function
REQ-014 SHALL implement states BOOT, FETCH, WAIT, HALT.
REQ-015 BOOT SHALL last exactly one cycle, then go to FETCH; imem_req_o=0 in BOOT.
REQ-016 FETCH and WAIT SHALL assert imem_req_o=1 with pc_o stable until imem_ready_i=1 ("completion").
REQ-017 FETCH without imem_ready_i SHALL go to WAIT; WAIT SHALL stay until completion.
REQ-018 At completion, priority SHALL be: pending/current redirect > stall_i > halt_i > increment.
REQ-019 Completion with redirect_i=1 or redirect pending: fetch_valid_o=0, pc <= redirect target, next state FETCH, pending cleared.
REQ-020 Completion with stall_i=1 (no redirect): fetch_valid_o=0, pc held, next state FETCH (same address re-fetched).
REQ-021 Completion with halt_i=1 (no redirect/stall): fetch_valid_o=1, pc held, next state HALT.
REQ-022 Otherwise at completion: fetch_valid_o=1, pc <= pc+2, next state FETCH.
REQ-023 PC increment SHALL wrap 16'hFFFE -> 16'h0000 with no flag.
REQ-024 redirect_i in WAIT (or FETCH without completion) SHALL latch redirect_pc_i into a pending register, keep pc_o unchanged, and discard the outstanding response (fetch_valid_o=0).
REQ-025 A later redirect_i before completion SHALL overwrite the pending target (latest wins).
REQ-026 redirect_i in BOOT SHALL load pc <= redirect_pc_i; next state FETCH.
REQ-027 HALT: imem_req_o=0, fetch_valid_o=0, halted_o=1, pc held; stall_i and halt_i ignored.
REQ-028 redirect_i in HALT SHALL load pc <= redirect_pc_i, clear halted_o next cycle, next state FETCH (squashed speculative HLT).
REQ-029 fetch_valid_o SHALL be 0 in every cycle that is not a completion.

Reset
REQ-030 rst_n=0 SHALL immediately force state BOOT, pc_o=RESET_PC, imem_req_o=0, fetch_valid_o=0, halted_o=0, pending redirect cleared.
REQ-031 Reset asserted mid-WAIT SHALL abandon the outstanding request with no further response consumed.
REQ-032 First imem_req_o after rst_n release SHALL occur in the second rising edge's cycle (after BOOT).

Structure
REQ-033 State encoding and RESET_PC default SHALL live in the shared CPU package.
REQ-034 The PC SHALL be held in one sub-module pc_hold_reg: 16-bit, write-enable, async active-low reset to RESET_PC.
REQ-035 Next-PC select and FSM SHALL be in pc_sequencer itself.

Verification
REQ-036 Reset, imem_ready_i=1 always, no other inputs -> pc_o 0000, 0002, 0004...; fetch_valid_o=1 each FETCH cycle.
REQ-037 pc=FFFE, completion -> pc_o=0000 next cycle.
REQ-038 imem_ready_i low 3 cycles at pc=0010, redirect_i to 0200 in 2nd wait cycle -> pc_o stays 0010, response discarded, next request at 0200.
REQ-039 Completion with stall_i=1 and halt_i=1 at pc=0020 -> fetch_valid_o=0, re-fetch 0020, no HALT.
REQ-040 halt_i at pc=0030 -> HALT, halted_o=1, imem_req_o=0; then redirect_i to 0040 -> fetch at 0040, halted_o=0.
REQ-041 rst_n low during WAIT at pc=0050 -> outputs reset asynchronously; restart fetch at RESET_PC.
